// File: rtl/route_loop_checker_if.sv
// Handshake and net-under-test signals between a route_loop_checker and its controller.
// The checker takes the slave view; the controller, loop and readback take the master view.
interface route_loop_checker_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             sense_i;
    logic             drive_o;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output start,
        output sense_i,
        input  drive_o,
        input  busy,
        input  done,
        input  fail,
        input  err_cnt
    );

    modport slave (
        input  start,
        input  sense_i,
        output drive_o,
        output busy,
        output done,
        output fail,
        output err_cnt
    );
endinterface

// File: rtl/route_loop_checker.sv
// PRBS7 loop checker: drives one routed arc, compares its far end against a
// LAT-deep copy of what was sent, and reports a sticky fail plus a saturating error count.
module route_loop_checker #(
    parameter int         LAT        = 1,
    parameter int         NUM_CYCLES = 127,
    parameter int         CNT_W      = 16,
    parameter logic [6:0] SEED       = 7'h01
) (
    input logic                 clk,
    input logic                 rst_n,
    route_loop_checker_if.slave bus
);

    localparam int               PH_W       = 16;
    localparam logic [PH_W-1:0]  PRIME_LAST = PH_W'(LAT - 1);
    localparam logic [PH_W-1:0]  RUN_LAST   = PH_W'(NUM_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       lfsr_q,  lfsr_d;
    logic [LAT-1:0]   exp_q,   exp_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] err_q,   err_d;
    logic             fail_q,  fail_d;

    logic active;
    logic drive;
    logic exp_bit;
    logic mismatch;

    assign active   = (state_q == S_PRIME) || (state_q == S_RUN);
    assign drive    = active & lfsr_q[0];
    assign exp_bit  = exp_q[LAT-1];
    assign mismatch = bus.sense_i ^ exp_bit;

    // The expected pipeline shifts in every state so it always mirrors the net's history.
    assign exp_d = LAT'({exp_q, drive});

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            exp_q   <= '0;
            phase_q <= '0;
            err_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            exp_q   <= exp_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // NOTE: every next-state signal is given its hold value first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        phase_d = phase_q;
        err_d   = err_q;
        fail_d  = fail_q;

        if (active) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_PRIME;
                    lfsr_d  = SEED;
                    phase_d = '0;
                    err_d   = '0;
                    fail_d  = 1'b0;
                end
            end

            S_PRIME: begin
                if (phase_q == PRIME_LAST) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_RUN: begin
                if (mismatch) begin
                    fail_d = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                end
                if (phase_q == RUN_LAST) begin
                    state_d = S_DONE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.drive_o = drive;
    assign bus.busy    = active;
    assign bus.done    = (state_q == S_DONE);
    assign bus.fail    = fail_q;
    assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_route_loop_checker.sv
// Bench for route_loop_checker: three instances (LAT=1, LAT=2, CNT_W=4) each closed
// through a modelled routed net; run results go through an expected-result queue.
module tb_route_loop_checker;

    localparam int         NUM  = 127;
    localparam logic [6:0] SEED = 7'h01;

    typedef enum int {M_IDEAL, M_STUCK0, M_INV} mode_e;
    typedef struct {
        int err;
        bit fail;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    route_loop_checker_if #(.CNT_W(16)) if_a ();
    route_loop_checker_if #(.CNT_W(16)) if_b ();
    route_loop_checker_if #(.CNT_W(4))  if_s ();

    route_loop_checker #(.LAT(1), .NUM_CYCLES(NUM), .CNT_W(16), .SEED(SEED)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    route_loop_checker #(.LAT(2), .NUM_CYCLES(NUM), .CNT_W(16), .SEED(SEED)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    route_loop_checker #(.LAT(1), .NUM_CYCLES(NUM), .CNT_W(4), .SEED(SEED)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s));

    logic        start_v [3];
    mode_e       mode_v  [3];
    int          depth_v [3];
    logic [1:0]  loop_sh [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        fail_v  [3];
    logic        drive_v [3];
    logic [15:0] err_v   [3];

    logic prbs [0:255];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Routed net model: one or two registers, optionally stuck at 0 or inverted.
    function automatic logic loop_out(input logic [1:0] sh, input int depth, input mode_e m);
        logic v;
        v = (depth == 2) ? sh[1] : sh[0];
        if (m == M_STUCK0) return 1'b0;
        if (m == M_INV)    return ~v;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        loop_sh[0] <= {loop_sh[0][0], if_a.drive_o};
        loop_sh[1] <= {loop_sh[1][0], if_b.drive_o};
        loop_sh[2] <= {loop_sh[2][0], if_s.drive_o};
    end

    assign if_a.start   = start_v[0];
    assign if_b.start   = start_v[1];
    assign if_s.start   = start_v[2];
    assign if_a.sense_i = loop_out(loop_sh[0], depth_v[0], mode_v[0]);
    assign if_b.sense_i = loop_out(loop_sh[1], depth_v[1], mode_v[1]);
    assign if_s.sense_i = loop_out(loop_sh[2], depth_v[2], mode_v[2]);

    always_comb begin
        busy_v[0]  = if_a.busy;    busy_v[1]  = if_b.busy;    busy_v[2]  = if_s.busy;
        done_v[0]  = if_a.done;    done_v[1]  = if_b.done;    done_v[2]  = if_s.done;
        fail_v[0]  = if_a.fail;    fail_v[1]  = if_b.fail;    fail_v[2]  = if_s.fail;
        drive_v[0] = if_a.drive_o; drive_v[1] = if_b.drive_o; drive_v[2] = if_s.drive_o;
        err_v[0]   = if_a.err_cnt;
        err_v[1]   = if_b.err_cnt;
        err_v[2]   = {12'h000, if_s.err_cnt};
    end

    // Expected mismatch count: RUN cycle j compares drive bit j with the net output,
    // which carries drive bit (lat + j - depth).
    function automatic int model_err(input int lat, input int depth, input mode_e m);
        int   cnt;
        logic s;
        cnt = 0;
        for (int j = 0; j < NUM; j++) begin
            case (m)
                M_STUCK0: s = 1'b0;
                M_INV:    s = ~prbs[lat + j - depth];
                default:  s = prbs[lat + j - depth];
            endcase
            if (s !== prbs[j]) cnt++;
        end
        return cnt;
    endfunction

    function automatic exp_t make_exp(input int lat, input int depth, input mode_e m, input int sat);
        exp_t e;
        int   raw;
        raw    = model_err(lat, depth, m);
        e.err  = (raw > sat) ? sat : raw;
        e.fail = (raw != 0);
        return e;
    endfunction

    // One complete run on instance idx; optionally pulses start again mid-RUN.
    task automatic run_case(input string name, input int idx, input int lat, input int depth,
                            input mode_e m, input int sat, input bit mid_start);
        exp_t e;
        mode_v[idx]  = m;
        depth_v[idx] = depth;
        sb.push_back(make_exp(lat, depth, m, sat));
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        for (int t = 0; t < lat + NUM; t++) begin
            n_checks++;
            if (busy_v[idx] !== 1'b1 || done_v[idx] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy/done cycle %0d: busy=%b done=%b, expected busy=1 done=0",
                         name, t + 1, busy_v[idx], done_v[idx]);
            end
            n_checks++;
            if (drive_v[idx] !== prbs[t]) begin
                n_fail++;
                $display("FAIL %s drive_o cycle %0d: got %b, expected %b",
                         name, t + 1, drive_v[idx], prbs[t]);
            end
            start_v[idx] = mid_start && (t == lat + 40);
            @(negedge clk);
        end
        start_v[idx] = 1'b0;
        n_checks++;
        if (done_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done edge: busy=%b done=%b, expected busy=0 done=1",
                     name, busy_v[idx], done_v[idx]);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: queue empty at done", name);
        end else begin
            e = sb.pop_front();
            if (err_v[idx] !== 16'(e.err) || fail_v[idx] !== e.fail) begin
                n_fail++;
                $display("FAIL %s result: err_cnt=%0d fail=%b, expected err_cnt=%0d fail=%b",
                         name, err_v[idx], fail_v[idx], e.err, e.fail);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || fail_v[i] !== 1'b0 ||
                drive_v[i] !== 1'b0 || err_v[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: busy=%b done=%b fail=%b drive=%b err=%0d, expected all 0",
                         i, busy_v[i], done_v[i], fail_v[i], drive_v[i], err_v[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ideal();
        run_case("ideal_lat1", 0, 1, 1, M_IDEAL, 65535, 1'b0);
    endtask

    task automatic test_stuck0();
        run_case("stuck0_lat1", 0, 1, 1, M_STUCK0, 65535, 1'b0);
    endtask

    task automatic test_inverted();
        run_case("inverted_lat1", 0, 1, 1, M_INV, 65535, 1'b0);
        run_case("inverted_sat4", 2, 1, 1, M_INV, 15, 1'b0);
    endtask

    task automatic test_latency();
        run_case("lat2_loop1", 1, 2, 1, M_IDEAL, 65535, 1'b0);
        n_checks++;
        if (err_v[1] === 16'd0) begin
            n_fail++;
            $display("FAIL lat2_loop1 nonzero: err_cnt=%0d, expected nonzero", err_v[1]);
        end
        run_case("lat2_loop2", 1, 2, 2, M_IDEAL, 65535, 1'b0);
    endtask

    task automatic test_mid_start();
        run_case("mid_run_start", 0, 1, 1, M_STUCK0, 65535, 1'b1);
    endtask

    // start held high across DONE: one-cycle done, then an immediate fresh run.
    task automatic test_back_to_back();
        exp_t e;
        mode_v[0]  = M_STUCK0;
        depth_v[0] = 1;
        sb.push_back(make_exp(1, 1, M_STUCK0, 65535));
        sb.push_back(make_exp(1, 1, M_STUCK0, 65535));
        start_v[0] = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 1 + NUM; t++) begin
            n_checks++;
            if (busy_v[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b run1 busy cycle %0d: got %b, expected 1", t + 1, busy_v[0]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_v[0] !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL b2b run1 done: done=%b queue=%0d, expected done=1", done_v[0], sb.size());
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (err_v[0] !== 16'(e.err) || fail_v[0] !== e.fail) begin
                n_fail++;
                $display("FAIL b2b run1 result: err_cnt=%0d fail=%b, expected %0d %b",
                         err_v[0], fail_v[0], e.err, e.fail);
            end
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        n_checks++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || err_v[0] !== 16'd0 ||
            fail_v[0] !== 1'b0 || drive_v[0] !== prbs[0]) begin
            n_fail++;
            $display("FAIL b2b restart: done=%b busy=%b err=%0d fail=%b drive=%b, expected 0 1 0 0 %b",
                     done_v[0], busy_v[0], err_v[0], fail_v[0], drive_v[0], prbs[0]);
        end
        @(negedge clk);
        for (int t = 1; t < 1 + NUM; t++) begin
            n_checks++;
            if (busy_v[0] !== 1'b1 || drive_v[0] !== prbs[t]) begin
                n_fail++;
                $display("FAIL b2b run2 cycle %0d: busy=%b drive=%b, expected busy=1 drive=%b",
                         t + 1, busy_v[0], drive_v[0], prbs[t]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_v[0] !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL b2b run2 done: done=%b queue=%0d, expected done=1", done_v[0], sb.size());
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (err_v[0] !== 16'(e.err) || fail_v[0] !== e.fail) begin
                n_fail++;
                $display("FAIL b2b run2 result: err_cnt=%0d fail=%b, expected %0d %b",
                         err_v[0], fail_v[0], e.err, e.fail);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        mode_v[0]  = M_STUCK0;
        depth_v[0] = 1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int t = 0; t < 1 + 50; t++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || fail_v[0] !== 1'b0 ||
            drive_v[0] !== 1'b0 || err_v[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_run_reset async: busy=%b done=%b fail=%b drive=%b err=%0d, expected all 0",
                     busy_v[0], done_v[0], fail_v[0], drive_v[0], err_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || err_v[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_run_reset idle: busy=%b done=%b err=%0d, expected 0 0 0",
                     busy_v[0], done_v[0], err_v[0]);
        end
        run_case("post_reset_stuck0", 0, 1, 1, M_STUCK0, 65535, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [6:0] l;
        l = SEED;
        for (int i = 0; i < 256; i++) begin
            prbs[i] = l[0];
            l = {l[5:0], l[6] ^ l[5]};
        end
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = M_IDEAL;
            depth_v[i] = 1;
            loop_sh[i] = 2'b00;
        end

        test_reset();
        test_ideal();
        test_stuck0();
        test_inverted();
        test_latency();
        test_mid_start();
        test_back_to_back();
        test_reset_mid_run();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
